rc4_seq_ctrl: RTL
=================

RC4_SEQ_CTRL -- requirements
Module: rc4_seq_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 cfg_we  in  1  host write strobe into internal buffers.
REQ-004 cfg_addr  in  7  0-31 select key[0..31]; 32-95 select msg[0..63]; 96-127 are ignored.
REQ-005 cfg_wdata  in  8  host write data.
REQ-006 msg_len  in  7  message byte count, sampled at start; values above 64 saturate to 64.
REQ-007 start  in  1  single-cycle run request.
REQ-008 busy / done / pass / err  out  1 each  run active / run complete (sticky) / decrypted message equals original / watchdog expired.
REQ-009 core_rst  out  1  synchronous reset to the cipher core.
REQ-010 key_valid, key_in  out  1, 8  key stream to the core.
REQ-011 plain_read  in  1; plain_in_valid, plain_in  out  1, 8  plaintext supply port.
REQ-012 cipher_write, cipher_out  in  1, 8  ciphertext capture port.
REQ-013 cipher_read  in  1; cipher_in_valid, cipher_in  out  1, 8  ciphertext supply port.
REQ-014 plain_write, plain_out  in  1, 8  decrypted-byte capture port.
REQ-015 core_done  in  1  core finished.

Function
REQ-016 FSM states: IDLE, CRST, KEY, RUN, FIN.
REQ-017 IDLE: cfg_we writes the addressed buffer byte. start=1 latches len=min(msg_len,64), clears pointers and the mismatch flag, clears done/pass/err, and moves to CRST.
REQ-018 CRST: core_rst=1 for exactly 1 cycle; busy=1 from CRST through FIN; next state KEY.
REQ-019 KEY: key_valid=1 for 33 consecutive cycles K..K+32; key_in=key[n] in cycle K+1+n, and 0 in cycle K; then RUN.
REQ-020 plain_in_valid = RUN and (pptr < len), combinational; plain_in = msg[pptr]; pptr increments on each edge where plain_read=1 and plain_in_valid=1.
REQ-021 Each edge with cipher_write=1 in RUN stores cipher_out to cbuf[cwptr] and increments cwptr; writes with cwptr=64 are dropped.
REQ-022 cipher_in_valid = RUN and (pptr = len) and (crptr < cwptr); cipher_in = cbuf[crptr]; crptr increments on each edge where cipher_read=1 and cipher_in_valid=1.
REQ-023 Each edge with plain_write=1 in RUN compares plain_out with msg[optr], sets the sticky mismatch flag on inequality, and increments optr; extra writes (optr=len) set mismatch.
REQ-024 core_done=1 in RUN -> FIN; FIN sets done=1, pass=(not mismatch) and (optr=len) and (cwptr=len), busy=0, then IDLE.
REQ-025 done, pass and err hold until the next accepted start.
REQ-026 start and cfg_we are ignored while busy=1; buffer contents persist across runs.
REQ-027 len=0: no valid strobes are issued; run completes on core_done with pass=1.
REQ-028 Pointers are 7 bits wide and never wrap past 64.

Reset
REQ-029 rst=1: state IDLE; all pointers and flags 0; all outputs 0 (busy, done, pass, err, core_rst, key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid, cipher_in). Key/msg/cbuf contents are not reset.
REQ-030 rst mid-run aborts the run immediately; the next start after release runs normally.

Configuration
REQ-031 Macro RC4_SEQ_CTRL_WATCHDOG_EN defined: a 12-bit counter clears at start and counts each busy cycle. On reaching 4095 with no core_done, err=1, done=1, pass=0, and the FSM returns to IDLE. If core_done and expiry coincide, core_done wins.
REQ-032 Macro undefined: no counter is present and err is tied to 0.

Verification
REQ-033 key[n]=n, msg[n]=n, msg_len=64, start -> core_rst 1 cycle, key_valid 33 cycles, 64 cipher_write captures, done=1 pass=1 err=0.
REQ-034 msg_len=0, start -> no plain_in_valid or cipher_in_valid; done=1 pass=1.
REQ-035 msg_len=16; core model flips bit0 of the 6th plain_out -> done=1 pass=0.
REQ-036 start and cfg_we(addr 32, 0xFF) while busy -> ignored; msg[0] unchanged; a single run completes.
REQ-037 rst asserted during RUN at pptr=10 -> all outputs 0, state IDLE; a following start with msg_len=8 -> pass=1.
REQ-038 Macro defined, core_done held 0 -> err=1 done=1 pass=0 exactly 4095 busy cycles after CRST.

Source files
------------

// File: rtl/rc4_seq_ctrl.sv
// Sequencer around an RC4 cipher core: loads the key, streams a message through encryption
// and decryption, and checks the round trip. Optional watchdog: define RC4_SEQ_CTRL_WATCHDOG_EN.
module rc4_seq_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [6:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic [6:0]        msg_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err,
    output logic              core_rst,
    output logic              key_valid,
    output logic [DATA_W-1:0] key_in,
    input  logic              plain_read,
    output logic              plain_in_valid,
    output logic [DATA_W-1:0] plain_in,
    input  logic              cipher_write,
    input  logic [DATA_W-1:0] cipher_out,
    input  logic              cipher_read,
    output logic              cipher_in_valid,
    output logic [DATA_W-1:0] cipher_in,
    input  logic              plain_write,
    input  logic [DATA_W-1:0] plain_out,
    input  logic              core_done
);

    typedef enum logic [2:0] {IDLE, CRST, KEY, RUN, FIN} state_t;

    state_t            state;
    logic [6:0]        len;
    logic [6:0]        pptr;
    logic [6:0]        cwptr;
    logic [6:0]        crptr;
    logic [6:0]        optr;
    logic [5:0]        kcnt;
    logic              mismatch;
    logic [DATA_W-1:0] key_mem [32];
    logic [DATA_W-1:0] msg_mem [64];
    logic [DATA_W-1:0] cbuf    [64];

    logic [6:0] len_sat;
    logic       cap_cipher;
    logic [5:0] msg_idx;

    assign len_sat    = (msg_len > 7'd64) ? 7'd64 : msg_len;
    assign cap_cipher = (state == RUN) && cipher_write && (cwptr < 7'd64);
    // Addresses 32..95 map to msg 0..63; subtracting 32 modulo 64 just flips bit 5.
    assign msg_idx    = {~cfg_addr[5], cfg_addr[4:0]};

    assign plain_in_valid  = (state == RUN) && (pptr < len);
    assign plain_in        = plain_in_valid ? msg_mem[pptr[5:0]] : '0;
    assign cipher_in_valid = (state == RUN) && (pptr == len) && (crptr < cwptr);
    assign cipher_in       = cipher_in_valid ? cbuf[crptr[5:0]] : '0;

    // Buffer storage carries no reset; contents persist across runs.
    always_ff @(posedge clk) begin
        if (cfg_we && (state == IDLE)) begin
            if (cfg_addr < 7'd32)
                key_mem[cfg_addr[4:0]] <= cfg_wdata;
            else if (cfg_addr < 7'd96)
                msg_mem[msg_idx] <= cfg_wdata;
        end
        if (cap_cipher)
            cbuf[cwptr[5:0]] <= cipher_out;
    end

`ifdef RC4_SEQ_CTRL_WATCHDOG_EN
    logic [11:0] wd_cnt;
    logic        err_r;
    logic        wd_expire;

    assign err       = err_r;
    // Expires on the edge where the count of busy cycles reaches 4095.
    assign wd_expire = busy && (wd_cnt == 12'd4094);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            core_rst  <= 1'b0;
            key_valid <= 1'b0;
            key_in    <= '0;
            len       <= '0;
            pptr      <= '0;
            cwptr     <= '0;
            crptr     <= '0;
            optr      <= '0;
            kcnt      <= '0;
            mismatch  <= 1'b0;
`ifdef RC4_SEQ_CTRL_WATCHDOG_EN
            wd_cnt    <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len      <= len_sat;
                        pptr     <= '0;
                        cwptr    <= '0;
                        crptr    <= '0;
                        optr     <= '0;
                        mismatch <= 1'b0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        core_rst <= 1'b1;
                        state    <= CRST;
`ifdef RC4_SEQ_CTRL_WATCHDOG_EN
                        wd_cnt   <= '0;
                        err_r    <= 1'b0;
`endif
                    end
                end
                CRST: begin
                    core_rst  <= 1'b0;
                    key_valid <= 1'b1;
                    key_in    <= '0;
                    kcnt      <= '0;
                    state     <= KEY;
                end
                KEY: begin
                    // One leading zero byte, then key[0..31].
                    if (kcnt == 6'd32) begin
                        key_valid <= 1'b0;
                        key_in    <= '0;
                        state     <= RUN;
                    end else begin
                        key_in <= key_mem[kcnt[4:0]];
                        kcnt   <= kcnt + 6'd1;
                    end
                end
                RUN: begin
                    if (plain_read && plain_in_valid)
                        pptr <= pptr + 7'd1;
                    if (cap_cipher)
                        cwptr <= cwptr + 7'd1;
                    if (cipher_read && cipher_in_valid)
                        crptr <= crptr + 7'd1;
                    if (plain_write) begin
                        if (optr < len) begin
                            if (plain_out != msg_mem[optr[5:0]])
                                mismatch <= 1'b1;
                            optr <= optr + 7'd1;
                        end else begin
                            mismatch <= 1'b1;
                        end
                    end
                    if (core_done)
                        state <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    pass  <= !mismatch && (optr == len) && (cwptr == len);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef RC4_SEQ_CTRL_WATCHDOG_EN
            if (busy)
                wd_cnt <= wd_cnt + 12'd1;
            // A completing run (core_done in RUN, or already in FIN) takes priority over expiry.
            if (wd_expire && (state != FIN) && !((state == RUN) && core_done)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                err_r     <= 1'b1;
                core_rst  <= 1'b0;
                key_valid <= 1'b0;
                key_in    <= '0;
            end
`endif
        end
    end

endmodule
